// File: rtl/raycast_pkg.sv
// Shared types and constants for the raycaster column-bank path.
package raycast_pkg;

  typedef logic [1:0] bank_t;

  localparam int          NUM_COLS = 640;
  localparam int          COL_W    = 28;
  localparam int          ADDR_W   = 10;
  localparam logic [15:0] EOF_CMD  = 16'hFFFF;

  typedef enum logic {
    STAGE_LO,
    STAGE_HI
  } stage_e;

  // With three banks numbered 0..2, the one not named by a or b.
  function automatic bank_t free_bank(bank_t a, bank_t b);
    return bank_t'(2'd3 - a - b);
  endfunction

endpackage

// File: rtl/column_bank_scheduler_if.sv
// Avalon-MM write-only slave bundle feeding the column bank scheduler.
interface column_bank_scheduler_if;

  logic        chipselect;
  logic        write;
  logic [15:0] writedata;

  modport master (output chipselect, write, writedata);
  modport slave  (input  chipselect, write, writedata);

endinterface

// File: rtl/column_word_assembler.sv
// Packs LO/HI 16-bit writes into column words, tracks the column pointer and
// overflow, and flags end-of-frame commands.
module column_word_assembler
  import raycast_pkg::*;
#(
  parameter int NUM_COLS = raycast_pkg::NUM_COLS,
  parameter int COL_W    = raycast_pkg::COL_W,
  parameter int ADDR_W   = raycast_pkg::ADDR_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              accept,
  input  logic [15:0]       writedata,
  output logic              commit,
  output logic              load,
  output logic              word_valid,
  output logic [ADDR_W-1:0] word_addr,
  output logic [COL_W-1:0]  word_data,
  output logic              col_overflow
);

  localparam logic [ADDR_W-1:0] COL_LIMIT = ADDR_W'(NUM_COLS);

  stage_e            stage_q, stage_d;
  logic [15:0]       lo_q;
  logic [ADDR_W-1:0] col_ptr;
  logic              hi_write;

  assign commit   = accept && (stage_q == STAGE_LO) && (writedata == EOF_CMD);
  assign hi_write = accept && (stage_q == STAGE_HI);
  assign load     = hi_write && (col_ptr < COL_LIMIT);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) stage_q <= STAGE_LO;
    else       stage_q <= stage_d;
  end

  // NOTE: default first so every path assigns stage_d and no latch is inferred.
  always_comb begin
    stage_d = stage_q;
    if (accept) begin
      case (stage_q)
        STAGE_LO: if (writedata != EOF_CMD) stage_d = STAGE_HI;
        STAGE_HI: stage_d = STAGE_LO;
        default:  stage_d = STAGE_LO;
      endcase
    end
  end

  // NOTE: non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lo_q         <= '0;
      col_ptr      <= '0;
      word_valid   <= 1'b0;
      word_addr    <= '0;
      word_data    <= '0;
      col_overflow <= 1'b0;
    end else begin
      word_valid <= load;
      if (accept && (stage_q == STAGE_LO) && !commit) lo_q <= writedata;
      if (load) begin
        word_addr <= col_ptr;
        word_data <= {writedata[11:0], lo_q};
        col_ptr   <= col_ptr + 1'b1;
      end
      if (hi_write && !load) col_overflow <= 1'b1;
      if (commit) begin
        col_ptr      <= '0;
        col_overflow <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/column_bank_scheduler.sv
// Triple-buffer bank-role controller for the raycaster column RAMs.
// Optional feature macro: FRAME_STATS_EN enables the saturating drop counter.
module column_bank_scheduler
  import raycast_pkg::*;
#(
  parameter int NUM_COLS = raycast_pkg::NUM_COLS,
  parameter int COL_W    = raycast_pkg::COL_W,
  parameter int ADDR_W   = raycast_pkg::ADDR_W
) (
  input  logic                    clk,
  input  logic                    reset,
  column_bank_scheduler_if.slave  avs,
  input  logic                    vblank_start,
  output logic                    wr_en,
  output bank_t                   wr_bank,
  output logic [ADDR_W-1:0]       wr_addr,
  output logic [COL_W-1:0]        wr_data,
  output bank_t                   disp_bank,
  output logic                    ready_valid,
  output logic                    swap_pulse,
  output logic                    col_overflow,
  output logic [7:0]              drop_count
);

  logic  commit, load;
  bank_t wbank_q, rbank_q;
  bank_t disp_d, wbank_d, rbank_d;
  logic  rvalid_d, swap_d;

  column_word_assembler #(
    .NUM_COLS (NUM_COLS),
    .COL_W    (COL_W),
    .ADDR_W   (ADDR_W)
  ) u_assembler (
    .clk          (clk),
    .reset        (reset),
    .accept       (avs.chipselect && avs.write),
    .writedata    (avs.writedata),
    .commit       (commit),
    .load         (load),
    .word_valid   (wr_en),
    .word_addr    (wr_addr),
    .word_data    (wr_data),
    .col_overflow (col_overflow)
  );

  always_comb begin
    disp_d   = disp_bank;
    wbank_d  = wbank_q;
    rbank_d  = rbank_q;
    rvalid_d = ready_valid;
    swap_d   = 1'b0;
    if (commit && vblank_start) begin
      // The just-finished frame goes straight to the display.
      disp_d   = wbank_q;
      rvalid_d = 1'b0;
      swap_d   = 1'b1;
      wbank_d  = ready_valid ? rbank_q : disp_bank;
    end else if (commit) begin
      rbank_d  = wbank_q;
      rvalid_d = 1'b1;
      wbank_d  = ready_valid ? rbank_q : free_bank(disp_bank, wbank_q);
    end else if (vblank_start && ready_valid) begin
      disp_d   = rbank_q;
      rvalid_d = 1'b0;
      swap_d   = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      disp_bank   <= 2'd0;
      wbank_q     <= 2'd1;
      rbank_q     <= 2'd2;
      ready_valid <= 1'b0;
      swap_pulse  <= 1'b0;
      wr_bank     <= 2'd0;
    end else begin
      disp_bank   <= disp_d;
      wbank_q     <= wbank_d;
      rbank_q     <= rbank_d;
      ready_valid <= rvalid_d;
      swap_pulse  <= swap_d;
      if (load) wr_bank <= wbank_q;
    end
  end

`ifdef FRAME_STATS_EN
  logic       drop_event;
  logic [7:0] drop_q;

  assign drop_event = commit && ready_valid;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)                              drop_q <= '0;
    else if (drop_event && drop_q != 8'hFF) drop_q <= drop_q + 8'd1;
  end

  assign drop_count = drop_q;
`else
  assign drop_count = '0;
`endif

  a_no_write_to_display: assert property (
    @(posedge clk) disable iff (reset) wr_en |-> (wr_bank != disp_bank)
  );

endmodule

// File: tb/tb_column_bank_scheduler.sv
// Directed bench for column_bank_scheduler: packing, bank rotation, overflow, reset.
module tb_column_bank_scheduler;
  import raycast_pkg::*;

`ifdef FRAME_STATS_EN
  localparam int DROP_ONE = 1;
`else
  localparam int DROP_ONE = 0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        vblank_start;
  logic        wr_en;
  bank_t       wr_bank;
  logic [9:0]  wr_addr;
  logic [27:0] wr_data;
  bank_t       disp_bank;
  logic        ready_valid;
  logic        swap_pulse;
  logic        col_overflow;
  logic [7:0]  drop_count;

  int errors = 0;
  int checks = 0;
  int en_cnt = 0;
  int en_base;

  column_bank_scheduler_if avs ();

  column_bank_scheduler dut (
    .clk          (clk),
    .reset        (reset),
    .avs          (avs),
    .vblank_start (vblank_start),
    .wr_en        (wr_en),
    .wr_bank      (wr_bank),
    .wr_addr      (wr_addr),
    .wr_data      (wr_data),
    .disp_bank    (disp_bank),
    .ready_valid  (ready_valid),
    .swap_pulse   (swap_pulse),
    .col_overflow (col_overflow),
    .drop_count   (drop_count)
  );

  always #10 clk = ~clk;

  always @(negedge clk) if (wr_en === 1'b1) en_cnt++;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic settle();
    @(negedge clk);
    #1;
  endtask

  task automatic bus_write(input logic [15:0] d, input logic vb);
    @(negedge clk);
    avs.chipselect = 1'b1;
    avs.write      = 1'b1;
    avs.writedata  = d;
    vblank_start   = vb;
    @(negedge clk);
    avs.chipselect = 1'b0;
    avs.write      = 1'b0;
    vblank_start   = 1'b0;
  endtask

  task automatic commit_frame();
    bus_write(EOF_CMD, 1'b0);
  endtask

  task automatic pulse_vblank();
    @(negedge clk);
    vblank_start = 1'b1;
    @(negedge clk);
    vblank_start = 1'b0;
  endtask

  task automatic write_pair(input logic [15:0] lo, input logic [15:0] hi, input logic exp_en,
                            input bank_t exp_bank, input int exp_addr, input string tag);
    logic [27:0] exp_data;
    exp_data = {hi[11:0], lo};
    bus_write(lo, 1'b0);
    bus_write(hi, 1'b0);
    check({tag, ".wr_en"}, wr_en, exp_en);
    if (exp_en) begin
      check({tag, ".wr_bank"}, wr_bank, exp_bank);
      check({tag, ".wr_addr"}, wr_addr, exp_addr);
      check({tag, ".wr_data"}, wr_data, exp_data);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, ".disp_bank"}, disp_bank, 0);
    check({tag, ".ready_valid"}, ready_valid, 0);
    check({tag, ".swap_pulse"}, swap_pulse, 0);
    check({tag, ".wr_en"}, wr_en, 0);
    check({tag, ".wr_bank"}, wr_bank, 0);
    check({tag, ".wr_addr"}, wr_addr, 0);
    check({tag, ".wr_data"}, wr_data, 0);
    check({tag, ".col_overflow"}, col_overflow, 0);
    check({tag, ".drop_count"}, drop_count, 0);
  endtask

  task automatic apply_reset();
    @(negedge clk);
    #3 reset = 1'b1;
    #2 check_reset_outputs("reset");
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    reset          = 1'b1;
    vblank_start   = 1'b0;
    avs.chipselect = 1'b0;
    avs.write      = 1'b0;
    avs.writedata  = '0;
    #25 check_reset_outputs("por");
    @(negedge clk);
    reset = 1'b0;

    // Full frame into bank 1.
    en_base = en_cnt;
    for (int i = 0; i < 640; i++) write_pair(16'(i), 16'(i), 1'b1, 2'd1, i, $sformatf("t1.c%0d", i));
    settle();
    check("t1.pulses", en_cnt - en_base, 640);
    check("t1.disp", disp_bank, 0);
    check("t1.ovf", col_overflow, 0);

    // Commit then vblank: bank 1 displayed, bank 2 becomes the write bank.
    commit_frame();
    check("t2.ready_set", ready_valid, 1);
    check("t2.disp_before", disp_bank, 0);
    pulse_vblank();
    check("t2.swap", swap_pulse, 1);
    check("t2.ready_clr", ready_valid, 0);
    check("t2.disp_after", disp_bank, 1);
    settle();
    check("t2.swap_width", swap_pulse, 0);
    write_pair(16'h00AA, 16'h0BBB, 1'b1, 2'd2, 0, "t2.next");
    pulse_vblank();
    check("t2.no_swap", swap_pulse, 0);
    check("t2.disp_hold", disp_bank, 1);
    // Writes without chipselect, or chipselect without write, are ignored.
    @(negedge clk);
    avs.write = 1'b1; avs.writedata = EOF_CMD;
    @(negedge clk);
    avs.write = 1'b0; avs.chipselect = 1'b1;
    @(negedge clk);
    avs.chipselect = 1'b0;
    check("t2.gated", ready_valid, 0);
    write_pair(16'h0001, 16'h0002, 1'b1, 2'd2, 1, "t2.gated_pair");

    // Two commits before vblank: first ready frame dropped.
    commit_frame();
    check("t3.ready1", ready_valid, 1);
    write_pair(16'h0123, 16'h0456, 1'b1, 2'd0, 0, "t3.f2");
    commit_frame();
    check("t3.ready2", ready_valid, 1);
    pulse_vblank();
    check("t3.swap", swap_pulse, 1);
    check("t3.disp", disp_bank, 0);
    check("t3.drop", drop_count, DROP_ONE);

    // Commit coinciding with vblank, ready invalid then ready valid.
    apply_reset();
    bus_write(EOF_CMD, 1'b1);
    check("t4.swap", swap_pulse, 1);
    check("t4.disp", disp_bank, 1);
    check("t4.ready", ready_valid, 0);
    check("t4.drop", drop_count, 0);
    write_pair(16'h0007, 16'h0008, 1'b1, 2'd0, 0, "t4.w");
    commit_frame();
    check("t4b.ready", ready_valid, 1);
    bus_write(EOF_CMD, 1'b1);
    check("t4b.swap", swap_pulse, 1);
    check("t4b.disp", disp_bank, 2);
    check("t4b.ready", ready_valid, 0);
    check("t4b.drop", drop_count, DROP_ONE);
    write_pair(16'h0009, 16'h000A, 1'b1, 2'd0, 0, "t4b.w");

    // Overflow past the last column, cleared by commit.
    commit_frame();
    check("t5.ovf_clr0", col_overflow, 0);
    en_base = en_cnt;
    for (int i = 0; i < 640; i++) write_pair(16'(i), 16'(i), 1'b1, 2'd1, i, $sformatf("t5.c%0d", i));
    write_pair(16'h0280, 16'h0280, 1'b0, 2'd1, 640, "t5.extra");
    settle();
    check("t5.pulses", en_cnt - en_base, 640);
    check("t5.ovf", col_overflow, 1);
    commit_frame();
    check("t5.ovf_clr", col_overflow, 0);
    check("t5.drop", drop_count, 2 * DROP_ONE);
    write_pair(16'h1234, 16'hFFFF, 1'b1, 2'd0, 0, "t5.hi_ffff");

    // Asynchronous reset mid-frame with a half-written column pending.
    for (int i = 0; i < 300; i++)
      write_pair(16'(i + 100), 16'(i), 1'b1, 2'd0, i + 1, $sformatf("t6.c%0d", i));
    bus_write(16'h5555, 1'b0);
    check("t6.ready_pre", ready_valid, 1);
    apply_reset();
    write_pair(16'h0042, 16'h0043, 1'b1, 2'd1, 0, "t6.after");
    pulse_vblank();
    check("t6.no_swap", swap_pulse, 0);
    check("t6.disp", disp_bank, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
